// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift/rotate left/right and parallel load, plus a
// self-timed burst mode that runs a latched shift op for burst_len back-to-back edges.
module universal_shift_register #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic [WIDTH-1:0] par_in,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] out,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bmode_q, bmode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             burst_ok_s;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             sin_r,
    input logic             sin_l,
    input logic [WIDTH-1:0] load_val
  );
    logic [WIDTH-1:0] res;
    case (op)
      MODE_HOLD: res = cur;
      MODE_SHR:  res = {sin_r, cur[WIDTH-1:1]};
      MODE_SHL:  res = {cur[WIDTH-2:0], sin_l};
      MODE_ROR:  res = {cur[0], cur[WIDTH-1:1]};
      MODE_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_LOAD: res = load_val;
      default:   res = cur;
    endcase
    return res;
  endfunction

  // A burst is only accepted for a non-zero length and one of the four shift/rotate ops.
  assign burst_ok_s = burst_start && (burst_len != {CNT_W{1'b0}}) &&
                      (mode >= MODE_SHR) && (mode <= MODE_ROL);

  // Next-state logic for the IDLE/BURST controller and the data register.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    bmode_d = bmode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (burst_ok_s) begin
          state_d = ST_BURST;
          cnt_d   = burst_len;
          bmode_d = mode;
          busy_d  = 1'b1;
        end else if (enable) begin
          data_d = apply_op(mode, data_q, serial_in_r, serial_in_l, par_in);
        end else begin
          data_d = data_q;
        end
      end
      ST_BURST: begin
        data_d = apply_op(bmode_q, data_q, serial_in_r, serial_in_l, par_in);
        cnt_d  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      bmode_q <= MODE_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      bmode_q <= bmode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out          = data_q;
  assign serial_out_r = data_q[0];
  assign serial_out_l = data_q[WIDTH-1];
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_universal_shift_register;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] mode;
  logic       serial_in_r;
  logic       serial_in_l;
  logic [3:0] par_in;
  logic       burst_start;
  logic [2:0] burst_len;
  logic [3:0] out;
  logic       serial_out_r;
  logic       serial_out_l;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [3:0] o;
    logic       b;
    logic       d;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  event  obs_ev;

  universal_shift_register #(.WIDTH(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode),
    .serial_in_r(serial_in_r), .serial_in_l(serial_in_l), .par_in(par_in),
    .burst_start(burst_start), .burst_len(burst_len), .out(out),
    .serial_out_r(serial_out_r), .serial_out_l(serial_out_l),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Expect the given state after the next rising edge.
  task automatic chk(input string nm, input logic [3:0] eo, input logic eb, input logic ed);
    exp_t e;
    e.o = eo; e.b = eb; e.d = ed;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    @(negedge clock);
  endtask

  // Expect the given state right now (asynchronous reset observation).
  task automatic chk_now(input string nm, input logic [3:0] eo, input logic eb, input logic ed);
    exp_t e;
    e.o = eo; e.b = eb; e.d = ed;
    exp_q.push_back(e);
    name_q.push_back(nm);
    -> obs_ev;
    #2;
  endtask

  // Monitor: pops one expectation per observation point.
  initial begin
    exp_t  e;
    string nm;
    logic [7:0] act, req;
    forever begin
      @(posedge clock or obs_ev);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = {out, serial_out_l, serial_out_r, busy, done};
        req = {e.o, e.o[3], e.o[0], e.b, e.d};
        checks++;
        if (act !== req) begin
          failures++;
          $display("FAIL %s: got out=%b sol=%b sor=%b busy=%b done=%b, expected out=%b sol=%b sor=%b busy=%b done=%b",
                   nm, act[7:4], act[3], act[2], act[1], act[0],
                   req[7:4], req[3], req[2], req[1], req[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 3'b000; serial_in_r = 1'b0; serial_in_l = 1'b0;
    par_in = 4'b0000; burst_start = 1'b0; burst_len = 3'd0;
    repeat (2) @(negedge clock);
    chk("reset_state", 4'b0000, 1'b0, 1'b0);
    reset = 1'b0;

    // Shift right with serial_in_r=1, then hold with enable low
    enable = 1'b1; mode = 3'b001; serial_in_r = 1'b1;
    chk("shr_1", 4'b1000, 1'b0, 1'b0);
    chk("shr_2", 4'b1100, 1'b0, 1'b0);
    enable = 1'b0;
    chk("shr_hold", 4'b1100, 1'b0, 1'b0);

    // Load, rotate and the 11x hold encoding
    enable = 1'b1; mode = 3'b101; par_in = 4'b1010;
    chk("load", 4'b1010, 1'b0, 1'b0);
    mode = 3'b100;
    chk("rol", 4'b0101, 1'b0, 1'b0);
    mode = 3'b011;
    chk("ror", 4'b1010, 1'b0, 1'b0);
    mode = 3'b110;
    chk("mode110_hold", 4'b1010, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle
    enable = 1'b0;
    reset = 1'b1;
    chk_now("async_reset", 4'b0000, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Burst of 3 SHL with inputs toggled mid-burst
    enable = 1'b1; mode = 3'b101; par_in = 4'b1001;
    chk("burst_load", 4'b1001, 1'b0, 1'b0);
    burst_start = 1'b1; burst_len = 3'd3; mode = 3'b010; serial_in_l = 1'b0;
    chk("burst_accept", 4'b1001, 1'b1, 1'b0);
    burst_start = 1'b0; mode = 3'b101; par_in = 4'b1111; burst_len = 3'd7; serial_in_r = 1'b1;
    chk("burst_s1", 4'b0010, 1'b1, 1'b0);
    enable = 1'b0; mode = 3'b001;
    chk("burst_s2", 4'b0100, 1'b1, 1'b0);
    enable = 1'b1; mode = 3'b100;
    chk("burst_s3_done", 4'b1000, 1'b0, 1'b1);
    enable = 1'b0;
    chk("burst_after", 4'b1000, 1'b0, 1'b0);

    // Reset in the middle of a length-5 ROR burst
    burst_start = 1'b1; burst_len = 3'd5; mode = 3'b011;
    chk("rburst_accept", 4'b1000, 1'b1, 1'b0);
    burst_start = 1'b0;
    chk("rburst_s1", 4'b0100, 1'b1, 1'b0);
    chk("rburst_s2", 4'b0010, 1'b1, 1'b0);
    reset = 1'b1;
    chk_now("rburst_reset", 4'b0000, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0; enable = 1'b0;
    chk("post_reset_hold1", 4'b0000, 1'b0, 1'b0);
    chk("post_reset_hold2", 4'b0000, 1'b0, 1'b0);

    // Zero-length burst and non-shift burst fall back to normal ops
    enable = 1'b1; mode = 3'b101; par_in = 4'b0110;
    chk("edge_load", 4'b0110, 1'b0, 1'b0);
    burst_start = 1'b1; burst_len = 3'd0; mode = 3'b001; serial_in_r = 1'b1;
    chk("len0_shr", 4'b1011, 1'b0, 1'b0);
    burst_len = 3'd3; mode = 3'b101; par_in = 4'b0011;
    chk("burst_load_mode", 4'b0011, 1'b0, 1'b0);

    // Back-to-back bursts: second request held through the done cycle
    burst_len = 3'd1; mode = 3'b010; serial_in_l = 1'b1;
    chk("b2b_accept1", 4'b0011, 1'b1, 1'b0);
    burst_len = 3'd2; mode = 3'b100;
    chk("b2b_done1", 4'b0111, 1'b0, 1'b1);
    chk("b2b_accept2", 4'b0111, 1'b1, 1'b0);
    burst_start = 1'b0;
    chk("b2b_s1", 4'b1110, 1'b1, 1'b0);
    chk("b2b_done2", 4'b1101, 1'b0, 1'b1);
    enable = 1'b1; mode = 3'b111;
    chk("mode111_hold", 4'b1101, 1'b0, 1'b0);
    mode = 3'b000;
    chk("mode000_hold", 4'b1101, 1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
